// File: rtl/ufm_seq_pkg.sv
// Shared types and constants for the sequential UFM byte fetcher.
package ufm_seq_pkg;

    localparam int unsigned UFM_ADDR_W  = 15;
    localparam int unsigned UFM_LEN_W   = 16;
    localparam int unsigned UFM_LEN_MAX = 32768;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StGap,
        StDrain
    } state_e;

endpackage

// File: rtl/ufm_seq_fetch_if.sv
// Reader-side random-access port plus consumer-side byte stream of ufm_seq_fetch.
interface ufm_seq_fetch_if;

    logic [ufm_seq_pkg::UFM_ADDR_W-1:0] rd_addr;
    logic                               rd_en;
    logic [7:0]                         rd_data;
    logic                               rd_valid;
    logic [7:0]                         out_data;
    logic                               out_valid;
    logic                               out_ready;

    modport master (
        output rd_addr, rd_en, out_data, out_valid,
        input  rd_data, rd_valid, out_ready
    );

    modport slave (
        input  rd_addr, rd_en, out_data, out_valid,
        output rd_data, rd_valid, out_ready
    );

endinterface

// File: rtl/ufm_byte_fifo.sv
// Byte-wide synchronous FIFO with a registered head and head-valid flag.
module ufm_byte_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    input  logic                          flush,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic [7:0]                    head,
    output logic                          head_valid
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       head_q, head_d;
    logic             head_valid_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        head_d   = head_q;
        // A push landing on the new read slot means the queue was empty: bypass memory.
        if (count_d != '0) begin
            head_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            head_valid_q <= (count_d != '0);
        end
    end

    assign count      = count_q;
    assign head       = head_q;
    assign head_valid = head_valid_q;

endmodule

// File: rtl/ufm_seq_fetch.sv
// Walks consecutive UFM byte addresses through ufm_reader and streams the bytes out.
// Optional running checksum output enabled by defining UFM_SEQ_CSUM_EN.
module ufm_seq_fetch
    import ufm_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [UFM_ADDR_W-1:0] start_addr,
    input  logic [UFM_LEN_W-1:0]  length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
`ifdef UFM_SEQ_CSUM_EN
    output logic [7:0]            csum,
`endif
    ufm_seq_fetch_if.master       bus
);

    localparam int unsigned     CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    state_e                state_q;
    logic [UFM_ADDR_W-1:0] addr_q, rd_addr_q;
    logic [UFM_LEN_W-1:0]  remaining_q;
    logic                  rd_en_q, busy_q, done_q;

    logic [CNT_W-1:0] count, count_nxt;
    logic [7:0]       head;
    logic             head_valid;
    logic             capture, push, pop;

    assign capture = rd_en_q && bus.rd_valid;
    assign push    = capture && !abort;
    assign pop     = head_valid && bus.out_ready;

    // Occupancy after this edge; drives the registered rd_en so it tracks fifo_count.
    always_comb begin
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        if (abort) begin
            count_nxt = '0;
        end
    end

    ufm_byte_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.rd_data),
        .pop       (pop),
        .flush     (abort),
        .count     (count),
        .head      (head),
        .head_valid(head_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
                rd_en_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            if (length != '0) begin
                                addr_q      <= start_addr;
                                rd_addr_q   <= start_addr;
                                remaining_q <= length;
                                rd_en_q     <= 1'b1;
                                busy_q      <= 1'b1;
                                state_q     <= StReq;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    StReq: begin
                        if (capture) begin
                            addr_q      <= addr_q + UFM_ADDR_W'(1);
                            remaining_q <= remaining_q - UFM_LEN_W'(1);
                            rd_en_q     <= 1'b0;
                            state_q     <= (remaining_q == UFM_LEN_W'(1)) ? StDrain : StGap;
                        end else begin
                            rd_en_q <= (count_nxt != FULL);
                        end
                    end
                    StGap: begin
                        rd_addr_q <= addr_q;
                        rd_en_q   <= (count_nxt != FULL);
                        state_q   <= StReq;
                    end
                    StDrain: begin
                        if (count_nxt == '0) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef UFM_SEQ_CSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst || abort || (state_q == StIdle && start)) begin
            csum_q <= '0;
        end else if (push) begin
            csum_q <= csum_q + bus.rd_data;
        end
    end

    assign csum = csum_q;
`endif

    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.out_data  = head;
    assign bus.out_valid = head_valid;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_ufm_seq_fetch.sv
// Self-checking bench for ufm_seq_fetch with a behavioural ufm_reader and stream scoreboard.
module tb_ufm_seq_fetch;
    import ufm_seq_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [UFM_ADDR_W-1:0] start_addr;
    logic [UFM_LEN_W-1:0]  length;
    logic                  abort;
    logic                  busy;
    logic                  done;
`ifdef UFM_SEQ_CSUM_EN
    logic [7:0]            csum;
`endif

    ufm_seq_fetch_if bus();

    ufm_seq_fetch #(
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
`ifdef UFM_SEQ_CSUM_EN
        .csum      (csum),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random per cycle
    int rand_lat = 0;

    // Scoreboard state, written only by the monitor.
    logic [7:0]            got[$];
    logic [UFM_ADDR_W-1:0] cap_addr[$];
    int                    done_cnt = 0;
    int                    rden_cnt = 0;
    int                    cap_cnt  = 0;

    int rcnt;
    int lat;

    function automatic logic [7:0] mem_byte(input logic [UFM_ADDR_W-1:0] a);
        return a[7:0];
    endfunction

    // Reader: valid with the addressed byte after lat cycles of rd_en; valid may linger one cycle.
    always @(posedge clk) begin
        if (rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= 8'h00;
            rcnt         <= 0;
            lat          <= 2;
        end else if (bus.rd_en) begin
            if (rcnt + 1 >= lat) begin
                bus.rd_valid <= 1'b1;
                bus.rd_data  <= mem_byte(bus.rd_addr);
            end else begin
                bus.rd_valid <= 1'b0;
            end
            rcnt <= rcnt + 1;
        end else begin
            bus.rd_valid <= 1'b0;
            rcnt         <= 0;
            lat          <= (rand_lat != 0) ? int'($urandom_range(1, 3)) : 2;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            if (bus.rd_en && bus.rd_valid) begin
                cap_addr.push_back(bus.rd_addr);
                cap_cnt <= cap_cnt + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
            if (bus.rd_en) rden_cnt <= rden_cnt + 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_done(input string tag, input int budget, output logic [7:0] cs);
        bit seen;
        seen = 1'b0;
        cs   = 8'h00;
        for (int k = 0; k < budget; k++) begin
            step();
            if (done === 1'b1) begin
                seen = 1'b1;
`ifdef UFM_SEQ_CSUM_EN
                cs = csum;
`endif
                break;
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_stream(input string tag, input int gb, input logic [UFM_ADDR_W-1:0] a,
                                input int len, input logic [7:0] cs);
        logic [7:0]            sum;
        logic [UFM_ADDR_W-1:0] ai;
        sum = 8'h00;
        check({tag, " byte_count"}, 32'(got.size() - gb), 32'(len));
        for (int i = 0; i < len; i++) begin
            ai  = a + UFM_ADDR_W'(i);
            sum = sum + mem_byte(ai);
            if (gb + i < got.size()) check({tag, " byte"}, 32'(got[gb + i]), 32'(mem_byte(ai)));
        end
`ifdef UFM_SEQ_CSUM_EN
        check({tag, " csum"}, 32'(cs), 32'(sum));
`else
        if (cs != 8'h00) $display("note: unexpected csum sample 0x%0h", cs);
`endif
    endtask

    task automatic xfer(input string tag, input logic [UFM_ADDR_W-1:0] a, input int len,
                        input int mode);
        int         gb, db;
        logic [7:0] cs;
        gb         = got.size();
        db         = done_cnt;
        rdy_mode   = mode;
        start_addr = a;
        length     = UFM_LEN_W'(len);
        start      = 1'b1;
        step();
        start = 1'b0;
        check({tag, " busy_first"}, 32'(busy), 32'd1);
        check({tag, " rd_addr_first"}, 32'(bus.rd_addr), 32'(a));
        wait_done(tag, len * 24 + 100, cs);
        step(2);
        check({tag, " done_pulses"}, 32'(done_cnt - db), 32'd1);
        check_stream(tag, gb, a, len, cs);
    endtask

    initial begin
        int         gb, db, cb, rb;
        bit         found;
        logic [7:0] cs;
        logic [UFM_ADDR_W-1:0] ra;

        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        start_addr = '0;
        length     = '0;
        step(3);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", 32'(bus.out_data), 32'd0);
        check("reset rd_en", 32'(bus.rd_en), 32'd0);
        check("reset rd_addr", 32'(bus.rd_addr), 32'd0);
        rst = 1'b0;
        step(2);

        // Basic transfer
        xfer("basic", 15'h0010, 5, 1);

        // Back-pressure: four captures fill the FIFO, then reads stall
        rdy_mode = 0;
        gb = got.size();
        cb = cap_cnt;
        db = done_cnt;
        start_addr = 15'h0040;
        length     = 16'd10;
        start      = 1'b1;
        step();
        start = 1'b0;
        check("bp rd_en_first", 32'(bus.rd_en), 32'd1);
        step(40);
        check("bp captures", 32'(cap_cnt - cb), 32'(DEPTH));
        check("bp rd_en_stalled", 32'(bus.rd_en), 32'd0);
        check("bp rd_addr_hold", 32'(bus.rd_addr), 32'h0044);
        check("bp out_valid", 32'(bus.out_valid), 32'd1);
        check("bp head", 32'(bus.out_data), 32'(mem_byte(15'h0040)));
        rdy_mode = 1;
        wait_done("bp", 400, cs);
        step(2);
        check("bp done_pulses", 32'(done_cnt - db), 32'd1);
        check_stream("bp", gb, 15'h0040, 10, cs);

        // Address wrap
        cb = cap_addr.size();
        xfer("wrap", 15'h7FFE, 4, 1);
        for (int i = 0; i < 4; i++) begin
            ra = 15'h7FFE + UFM_ADDR_W'(i);
            if (cb + i < cap_addr.size()) check("wrap rd_addr", 32'(cap_addr[cb + i]), 32'(ra));
        end
        check("wrap captures", 32'(cap_addr.size() - cb), 32'd4);

        // Length zero
        rb = rden_cnt;
        db = done_cnt;
        start_addr = 15'h0123;
        length     = 16'd0;
        start      = 1'b1;
        step();
        start = 1'b0;
        check("len0 done", 32'(done), 32'd1);
        check("len0 busy", 32'(busy), 32'd0);
        step();
        check("len0 done_clear", 32'(done), 32'd0);
        step();
        check("len0 rd_en_cycles", 32'(rden_cnt - rb), 32'd0);
        check("len0 done_pulses", 32'(done_cnt - db), 32'd1);

        // Start while busy is ignored
        gb = got.size();
        db = done_cnt;
        start_addr = 15'h0100;
        length     = 16'd6;
        start      = 1'b1;
        step();
        start = 1'b0;
        step(4);
        start_addr = 15'h0200;
        length     = 16'd3;
        start      = 1'b1;
        step();
        start = 1'b0;
        wait_done("restart", 300, cs);
        step(2);
        check("restart done_pulses", 32'(done_cnt - db), 32'd1);
        check_stream("restart", gb, 15'h0100, 6, cs);

        // Abort coinciding with a capture while two bytes are queued
        rdy_mode = 0;
        cb = cap_cnt;
        db = done_cnt;
        start_addr = 15'h0300;
        length     = 16'd10;
        start      = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if ((cap_cnt - cb == 2) && bus.rd_en && bus.rd_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("abort window_found", 32'(found), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort rd_en", 32'(bus.rd_en), 32'd0);
        rdy_mode = 1;
        step(5);
        check("abort no_done", 32'(done_cnt - db), 32'd0);
        check("abort stays_empty", 32'(bus.out_valid), 32'd0);
        xfer("post_abort", 15'h0123, 3, 1);

        // Reset mid-transfer
        start_addr = 15'h0500;
        length     = 16'd8;
        start      = 1'b1;
        step();
        start = 1'b0;
        step(5);
        rst = 1'b1;
        step();
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst rd_en", 32'(bus.rd_en), 32'd0);
        check("midrst rd_addr", 32'(bus.rd_addr), 32'd0);
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst out_data", 32'(bus.out_data), 32'd0);
        rst = 1'b0;
        step(2);

        // Randomised transfers with random reader latency and consumer back-pressure
        rand_lat = 1;
        for (int t = 0; t < 8; t++) begin
            ra = UFM_ADDR_W'($urandom_range(0, 32767));
            xfer("rand", ra, int'($urandom_range(1, 24)), 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
